// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver: FSM state encoding,
// frame-shape defaults and counter width helpers.
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The tick counter must reach both 15 (bit length) and SB_TICK-1 (stop length).
  function automatic int s_cnt_w(input int sb_tick);
    return (cnt_w(sb_tick) > 4) ? cnt_w(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and result-side signals of the UART receiver, plus FSM debug taps.
interface uart_rx_if import uart_pkg::*; #(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) ();

  localparam int SW = s_cnt_w(SB_TICK);
  localparam int NW = cnt_w(DBIT);

  // No back-pressure: rx_done_tick is a one-clk strobe, dout/frame_err are
  // valid from that cycle on and held until the next strobe.
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  state_t          dbg_state;
  logic [SW-1:0]   dbg_s_cnt;
  logic [NW-1:0]   dbg_n_cnt;

  modport master (
    output rx, s_tick,
    input  rx_done_tick, dout, frame_err, dbg_state, dbg_s_cnt, dbg_n_cnt
  );

  modport slave (
    input  rx, s_tick,
    output rx_done_tick, dout, frame_err, dbg_state, dbg_s_cnt, dbg_n_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 16 ticks per bit, mid-bit sampling, LSB first,
// configurable data width and stop length.
module uart_rx import uart_pkg::*; #(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int SW = s_cnt_w(SB_TICK);
  localparam int NW = cnt_w(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            w_rx_s;
  logic [DBIT-1:0] w_shift_in;

  state_t          r_state,  w_state_n;
  logic [SW-1:0]   r_s_cnt,  w_s_cnt_n;
  logic [NW-1:0]   r_n_cnt,  w_n_cnt_n;
  logic [DBIT-1:0] r_shift,  w_shift_n;
  logic [DBIT-1:0] r_dout,   w_dout_n;
  logic            r_ferr,   w_ferr_n;
  logic            r_done,   w_done_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  // New bit enters at the MSB so that after DBIT shifts bit 0 sits at the LSB.
  if (DBIT > 1) begin : g_shift_wide
    assign w_shift_in = {w_rx_s, r_shift[DBIT-1:1]};
  end else begin : g_shift_one
    assign w_shift_in = w_rx_s;
  end

  always_comb begin
    w_state_n = r_state;
    w_s_cnt_n = r_s_cnt;
    w_n_cnt_n = r_n_cnt;
    w_shift_n = r_shift;
    w_dout_n  = r_dout;
    w_ferr_n  = r_ferr;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_n = START;
          w_s_cnt_n = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (r_s_cnt == S_HALF) begin
            w_s_cnt_n = '0;
            if (!w_rx_s) begin
              w_state_n = DATA;
              w_n_cnt_n = '0;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_s_cnt_n = r_s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (r_s_cnt == S_BIT) begin
            w_s_cnt_n = '0;
            w_shift_n = w_shift_in;
            if (r_n_cnt == N_LAST) w_state_n = STOP;
            else                   w_n_cnt_n = r_n_cnt + NW'(1);
          end else begin
            w_s_cnt_n = r_s_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (r_s_cnt == S_STOP) begin
            w_state_n = IDLE;
            w_s_cnt_n = '0;
            w_dout_n  = r_shift;
            w_ferr_n  = ~w_rx_s;
            w_done_n  = 1'b1;
          end else begin
            w_s_cnt_n = r_s_cnt + SW'(1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // The done strobe is registered so it lines up with the new dout/frame_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_s_cnt <= w_s_cnt_n;
      r_n_cnt <= w_n_cnt_n;
      r_shift <= w_shift_n;
      r_dout  <= w_dout_n;
      r_ferr  <= w_ferr_n;
      r_done  <= w_done_n;
    end
  end

  assign bus.rx_done_tick = r_done;
  assign bus.dout         = r_dout;
  assign bus.frame_err    = r_ferr;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_s_cnt    = r_s_cnt;
  assign bus.dbg_n_cnt    = r_n_cnt;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: normal, false-start, stop-error, back-to-back,
// mid-frame reset and slow/frozen tick frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;

  logic clk;
  logic reset;

  uart_rx_if #(.DBIT(DBIT), .SB_TICK(SB_TICK)) bus ();

  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset / tick generator ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tick_div    = 1;
  bit tick_freeze = 1'b0;
  int tick_phase  = 0;

  initial begin
    bus.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_freeze) begin
        bus.s_tick = 1'b0;
      end else if (tick_phase >= tick_div - 1) begin
        bus.s_tick = 1'b1;
        tick_phase = 0;
      end else begin
        bus.s_tick = 1'b0;
        tick_phase++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];   // {frame_err, dout}
  int done_cnt = 0;
  int unsigned pulse_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev_done;
    logic [8:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_done_tick === 1'b1) begin
        done_cnt++;
        pulse_cyc = cyc;
        check("no_double_pulse", {31'd0, prev_done}, 32'd0);
        check("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("dout", {24'd0, bus.dout}, {24'd0, e[7:0]});
          check("frame_err", {31'd0, bus.frame_err}, {31'd0, e[8]});
        end
      end
      prev_done = bus.rx_done_tick;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    int n;
    bus.rx = b;
    n = 0;
    while (n < 16) begin
      @(negedge clk);
      if (bus.s_tick) n++;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
    bus.rx = 1'b1;
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check(tag, done_cnt, target);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned start_cyc;
    int base;
    state_t snap_state;
    logic [3:0] snap_s;
    logic [2:0] snap_n;
    bit changed;

    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    check("rst_s_cnt", 32'(bus.dbg_s_cnt), 32'd0);
    check("rst_n_cnt", 32'(bus.dbg_n_cnt), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_done", 32'(bus.rx_done_tick), 32'd0);
    reset = 1'b0;
    idle(20);

    // Normal frame 0xA5, tick every clk
    exp_q.push_back({1'b0, 8'hA5});
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    wait_pulses("a5_pulse_count", 1, 200);
    check("a5_latency_ok", {31'd0, (pulse_cyc - start_cyc) <= 162}, 32'd1);
    idle(40);

    // False start: low for 3 ticks only
    bus.rx = 1'b0;
    idle(3);
    bus.rx = 1'b1;
    idle(40);
    check("false_start_state", 32'(bus.dbg_state), 32'(IDLE));
    check("false_start_no_pulse", done_cnt, 1);
    check("false_start_dout", 32'(bus.dout), 32'hA5);

    // Stop bit driven low
    exp_q.push_back({1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0);
    wait_pulses("3c_pulse_count", 2, 200);
    idle(60);
    check("3c_no_extra_pulse", done_cnt, 2);

    // Back-to-back frames without idle gap
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_pulses("b2b_pulse_count", 4, 200);
    idle(40);
    check("b2b_dout_last", 32'(bus.dout), 32'hFF);

    // Reset during data bit 4 of 0x55, then frame 0x81
    base = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    bus.rx = 1'b1;
    idle(8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
    check("midrst_s_cnt", 32'(bus.dbg_s_cnt), 32'd0);
    check("midrst_n_cnt", 32'(bus.dbg_n_cnt), 32'd0);
    check("midrst_dout", 32'(bus.dout), 32'd0);
    idle(100);
    check("midrst_no_pulse", done_cnt, base);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1);
    wait_pulses("81_pulse_count", base + 1, 200);
    idle(40);
    check("81_dout", 32'(bus.dout), 32'h81);

    // Slow tick (1 in 3) with a 50-clk freeze mid-frame
    tick_div = 3;
    idle(10);
    base = done_cnt;
    exp_q.push_back({1'b0, 8'h6E});
    fork
      send_frame(8'h6E, 1'b1);
      begin
        idle(200);
        tick_freeze = 1'b1;
        idle(2);
        snap_state = bus.dbg_state;
        snap_s     = bus.dbg_s_cnt;
        snap_n     = bus.dbg_n_cnt;
        check("freeze_in_data", 32'(snap_state), 32'(DATA));
        changed = 1'b0;
        repeat (50) begin
          @(negedge clk);
          if (bus.dbg_state != snap_state || bus.dbg_s_cnt != snap_s ||
              bus.dbg_n_cnt != snap_n || bus.rx_done_tick)
            changed = 1'b1;
        end
        check("freeze_hold", {31'd0, changed}, 32'd0);
        tick_freeze = 1'b0;
      end
    join
    wait_pulses("6e_pulse_count", base + 1, 600);
    idle(60);
    check("6e_dout", 32'(bus.dout), 32'h6E);
    check("6e_frame_err", 32'(bus.frame_err), 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame, LSB first.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  sole clock; all flops on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 s_tick  input  1  one-clk-wide sample enable at 16x baud, driven by the team's mod-M tick generator max_tick.
REQ-007 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-008 dout  output  DBIT  last completed data byte; held until next completion.
REQ-009 frame_err  output  1  stop-bit status of last completed frame (1 = stop sampled low); updates only with rx_done_tick.

Function
REQ-010 rx SHALL pass a 2-flop synchronizer; rx_s (second flop) is the only rx value used internally; latency 2 clk.
REQ-011 FSM states: IDLE, START, DATA, STOP; all counters advance only in cycles where s_tick=1, except the IDLE exit.
REQ-012 IDLE: rx_s=0 -> START with s_cnt=0 on the next clk, regardless of s_tick.
REQ-013 START: on s_tick, s_cnt==7 and rx_s=0 -> DATA, s_cnt=0, n_cnt=0; s_cnt==7 and rx_s=1 -> IDLE (false start, no output change); otherwise s_cnt+1.
REQ-014 DATA: on s_tick, s_cnt==15 -> s_cnt=0, shift_reg={rx_s, shift_reg[DBIT-1:1]}; n_cnt==DBIT-1 -> STOP, else n_cnt+1; otherwise s_cnt+1.
REQ-015 STOP: on s_tick, s_cnt==SB_TICK-1 -> IDLE, dout<=shift_reg, frame_err<=~rx_s, rx_done_tick=1 for exactly that cycle; otherwise s_cnt+1.
REQ-016 Bits SHALL be sampled at mid-bit: 8 ticks after the start edge, then every 16 ticks.
REQ-017 s_cnt width SHALL cover SB_TICK-1; n_cnt width SHALL cover DBIT-1; counter compares are exact, no wrap past the terminal value.
REQ-018 s_tick held low SHALL freeze the FSM and counters (IDLE exit excepted).
REQ-019 Frame with stop error SHALL still update dout and pulse rx_done_tick.
REQ-020 Back-to-back frames: a start edge detected in the clk following the STOP->IDLE transition SHALL be received without loss.
REQ-021 rx_done_tick SHALL never be asserted for two consecutive clk.

Reset
REQ-022 reset=1 at any rising clk edge, including mid-frame, SHALL force: state=IDLE, s_cnt=0, n_cnt=0, shift_reg=0, dout=0, frame_err=0, rx_done_tick=0, both synchronizer flops=1.
REQ-023 A frame interrupted by reset SHALL produce no rx_done_tick; reception restarts at the next falling edge after reset release.

Structure
REQ-024 A shared package uart_pkg SHALL hold the state enum type and the DBIT/SB_TICK default constants.
REQ-025 The synchronizer SHALL be a sub-module sync_2ff (1 bit, reset value parameter, set to 1 here).
REQ-026 FSM in one registered-state/combinational-next-state pair; no latches; all outputs registered except rx_done_tick (Moore decode of STOP terminal condition permitted).

Verification
REQ-027 s_tick=1 every clk, frame 0xA5 with 1 stop -> single rx_done_tick, dout=0xA5, frame_err=0, pulse within 16*10+2 clk of the start edge.
REQ-028 rx low for 3 ticks then high -> FSM back to IDLE, no rx_done_tick, dout unchanged.
REQ-029 frame 0x3C with stop bit driven low -> rx_done_tick, dout=0x3C, frame_err=1.
REQ-030 back-to-back 0x00 then 0xFF, no idle gap -> two rx_done_ticks, dout 0x00 then 0xFF, frame_err=0 both.
REQ-031 reset asserted 1 clk during data bit 4 of 0x55, then frame 0x81 -> no pulse for 0x55; dout=0x81 after second pulse.
REQ-032 s_tick 1-in-3 clk (mod-M=3), frame 0x6E -> dout=0x6E, frame_err=0; s_tick forced low 50 clk mid-frame -> state and counters unchanged over that window.
